// File: rtl/lsu_mem_responder_pkg.sv
// Shared LSU request encodings and responder FSM states, reusable by initiators.
package lsu_mem_responder_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StDone
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_responder_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for writes,
// lane extraction plus sign/zero extension for loads, and size/alignment errors.
import lsu_mem_responder_pkg::*;

module lsu_lane_align (
    input  logic [2:0]  lsu_type,
    input  logic [1:0]  addr_lo,
    input  logic        is_write,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        align_err
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_sh  = 32'h0;
        rdata_ext = 32'h0;
        align_err = 1'b0;
        case (lsu_type)
            LSU_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{rbyte[7]}}, rbyte};
            end
            LSU_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{rhalf[15]}}, rhalf};
                align_err = addr_lo[0];
            end
            LSU_W: begin
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
                align_err = (addr_lo != 2'b00);
            end
            // Unsigned codes exist only for loads.
            LSU_BU: begin
                rdata_ext = {24'h0, rbyte};
                align_err = is_write;
            end
            LSU_HU: begin
                rdata_ext = {16'h0, rhalf};
                align_err = is_write | addr_lo[0];
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// LSU responder: one request at a time, fixed wait states, word array with byte lanes,
// registered one-cycle done pulse with error qualifier and extended load data.
import lsu_mem_responder_pkg::*;

module lsu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_type,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_err
);

    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    lsu_state_e  state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  type_q;
    logic        wr_q;
    logic        conflict_q;

    logic [IdxW-1:0] word_idx;
    logic [31:0]     rword;
    logic [3:0]      be;
    logic [31:0]     wdata_sh;
    logic [31:0]     rdata_ext;
    logic            align_err;
    logic            range_err;
    logic            acc_err;

    assign word_idx  = addr_q[IdxW+1:2];
    // Full 30-bit word index is checked so high addresses never alias.
    assign range_err = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
    assign acc_err   = align_err | range_err | conflict_q;
    assign rword     = range_err ? 32'h0 : mem[word_idx];

    lsu_lane_align u_lane_align (
        .lsu_type  (type_q),
        .addr_lo   (addr_q[1:0]),
        .is_write  (wr_q),
        .wdata     (wdata_q),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .align_err (align_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            type_q     <= 3'b000;
            wr_q       <= 1'b0;
            conflict_q <= 1'b0;
            lsu_done   <= 1'b0;
            lsu_err    <= 1'b0;
            lsu_rdata  <= 32'h0;
        end else begin
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= 32'h0;
            unique case (state)
                StIdle: begin
                    if (lsu_ren || lsu_wen) begin
                        addr_q     <= lsu_addr;
                        wdata_q    <= lsu_wdata;
                        type_q     <= lsu_type;
                        wr_q       <= lsu_wen;
                        conflict_q <= lsu_ren & lsu_wen;
                        if (WAIT_STATES > 0) begin
                            state <= StWait;
                            cnt   <= WaitInit;
                        end else begin
                            state <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (cnt == 4'd0) state <= StAccess;
                    else             cnt   <= cnt - 4'd1;
                end
                StAccess: begin
                    lsu_done  <= 1'b1;
                    lsu_err   <= acc_err;
                    lsu_rdata <= (acc_err || wr_q) ? 32'h0 : rdata_ext;
                    state     <= StDone;
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Array is deliberately not reset; a reset before ACCESS leaves it untouched.
    always_ff @(posedge clk) begin
        if (state == StAccess && wr_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

endmodule
